// File: rtl/store_buffer_if.sv
// Bus bundle for the store buffer: store request side, dmem write side, load-hazard probe and status.
// Valid/ready: a transfer happens on a rising edge where valid && ready; the source holds its payload while valid && !ready.
interface store_buffer_if;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_size;
  logic        mem_wvalid;
  logic        mem_wready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        ld_check;
  logic [31:0] ld_addr;
  logic        ld_hazard;
  logic        empty;
  logic        misalign_err;

  modport slave (
    input  st_valid, st_addr, st_data, st_size, mem_wready, ld_check, ld_addr,
    output st_ready, mem_wvalid, mem_addr, mem_wdata, mem_wmask, ld_hazard, empty, misalign_err
  );

  modport master (
    output st_valid, st_addr, st_data, st_size, mem_wready, ld_check, ld_addr,
    input  st_ready, mem_wvalid, mem_addr, mem_wdata, mem_wmask, ld_hazard, empty, misalign_err
  );
endinterface

// File: rtl/store_buffer.sv
// Store buffer: aligns execute-stage stores into word address / lane data / byte mask,
// queues them in a FIFO drained to dmem, and flags loads that hit a pending store.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input logic           clk,
  input logic           rst_n,
  store_buffer_if.slave bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [29:0]      ent_addr_q [DEPTH];
  logic [29:0]      ent_addr_d [DEPTH];
  logic [31:0]      ent_data_q [DEPTH];
  logic [31:0]      ent_data_d [DEPTH];
  logic [3:0]       ent_mask_q [DEPTH];
  logic [3:0]       ent_mask_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             misalign_err_q, misalign_err_d;

  logic [1:0]  al_off;
  logic        al_ok;
  logic [3:0]  al_mask;
  logic [31:0] al_wdata;
  logic        enq, deq;
  logic        hit;
  logic        unused_ld_low;

  assign unused_ld_low = ^bus.ld_addr[1:0];

  // Lane placement; unmasked lanes stay zero because the source is zero-extended before shifting.
  always_comb begin
    al_off   = bus.st_addr[1:0];
    al_ok    = 1'b0;
    al_mask  = 4'b0000;
    al_wdata = 32'd0;
    unique case (bus.st_size)
      2'b00: begin
        al_ok    = 1'b1;
        al_mask  = 4'b0001 << al_off;
        al_wdata = {24'd0, bus.st_data[7:0]} << {al_off, 3'b000};
      end
      2'b01: begin
        al_ok    = !bus.st_addr[0];
        al_mask  = 4'b0011 << al_off;
        al_wdata = {16'd0, bus.st_data[15:0]} << {al_off, 3'b000};
      end
      2'b10: begin
        al_ok    = (al_off == 2'b00);
        al_mask  = 4'b1111;
        al_wdata = bus.st_data;
      end
      default: begin
        al_ok = 1'b0;
      end
    endcase
  end

  assign bus.st_ready     = (count_q != FULL);
  assign bus.mem_wvalid   = (count_q != '0);
  assign bus.empty        = (count_q == '0);
  assign bus.mem_addr     = {ent_addr_q[rd_ptr_q], 2'b00};
  assign bus.mem_wdata    = ent_data_q[rd_ptr_q];
  assign bus.mem_wmask    = ent_mask_q[rd_ptr_q];
  assign bus.misalign_err = misalign_err_q;

  assign enq = bus.st_valid && bus.st_ready && al_ok;
  assign deq = bus.mem_wvalid && bus.mem_wready;

  always_comb begin
    ent_addr_d     = ent_addr_q;
    ent_data_d     = ent_data_q;
    ent_mask_d     = ent_mask_q;
    valid_d        = valid_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    misalign_err_d = bus.st_valid && bus.st_ready && !al_ok;

    // Enqueue and dequeue never target the same slot: a full buffer refuses stores.
    if (deq) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PTR_W'(1);
    end
    if (enq) begin
      ent_addr_d[wr_ptr_q] = bus.st_addr[31:2];
      ent_data_d[wr_ptr_q] = al_wdata;
      ent_mask_d[wr_ptr_q] = al_mask;
      valid_d[wr_ptr_q]    = 1'b1;
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
    end
    if (enq && !deq) begin
      count_d = count_q + CNT_W'(1);
    end else if (deq && !enq) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Only stored entries are compared; a store enqueuing this cycle is not yet visible.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (ent_addr_q[i] == bus.ld_addr[31:2])) begin
        hit = 1'b1;
      end
    end
  end

  assign bus.ld_hazard = bus.ld_check && hit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q        <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      misalign_err_q <= 1'b0;
    end else begin
      valid_q        <= valid_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      misalign_err_q <= misalign_err_d;
    end
  end

  // Payload storage needs no reset; valid bits and count gate every use of it.
  always_ff @(posedge clk) begin
    ent_addr_q <= ent_addr_d;
    ent_data_q <= ent_data_d;
    ent_mask_q <= ent_mask_d;
  end
endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: a queue-based model of the buffer checked every cycle, plus directed
// stores with hand-computed expectations for alignment, ordering, full, hazard, misalign and reset.
module tb_store_buffer;
  localparam int DEPTH = 4;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  bit   checking;

  store_buffer_if bus();

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected queue: each entry is {word_addr[29:0], wdata[31:0], mask[3:0]}.
  logic [65:0] exp_q[$];
  logic        exp_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Byte-by-byte placement of the store into its word lanes.
  function automatic logic [65:0] model_entry(input logic [31:0] addr, input logic [31:0] data,
                                              input logic [1:0] size, output bit ok);
    int          n;
    int          off;
    logic [3:0]  mask;
    logic [31:0] wdata;
    n     = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    off   = int'(addr[1:0]);
    ok    = (size != 2'd3) && ((off % n) == 0);
    mask  = 4'd0;
    wdata = 32'd0;
    if (ok) begin
      for (int b = 0; b < n; b++) begin
        mask[off + b]              = 1'b1;
        wdata[8*(off + b) +: 8]    = data[8*b +: 8];
      end
    end
    return {addr[31:2], wdata, mask};
  endfunction

  // Model update on the active edge, using inputs driven 1 time unit after the previous edge.
  always @(posedge clk) begin
    bit          ok;
    bit          ready;
    bit          do_deq;
    logic [65:0] e;
    if (!rst_n) begin
      exp_q.delete();
      exp_err = 1'b0;
    end else begin
      ready   = (exp_q.size() < DEPTH);
      e       = model_entry(bus.st_addr, bus.st_data, bus.st_size, ok);
      do_deq  = (exp_q.size() > 0) && bus.mem_wready;
      exp_err = bus.st_valid && ready && !ok;
      if (do_deq) void'(exp_q.pop_front());
      if (bus.st_valid && ready && ok) exp_q.push_back(e);
    end
  end

  // Compare process: every negedge once the first reset has been applied.
  always @(negedge clk) begin
    bit hz;
    if (checking) begin
      hz = 1'b0;
      foreach (exp_q[i]) if (exp_q[i][65:36] == bus.ld_addr[31:2]) hz = 1'b1;
      chk("cyc_wvalid", 32'(bus.mem_wvalid), 32'(exp_q.size() > 0));
      chk("cyc_empty", 32'(bus.empty), 32'(exp_q.size() == 0));
      chk("cyc_st_ready", 32'(bus.st_ready), 32'(exp_q.size() < DEPTH));
      chk("cyc_misalign", 32'(bus.misalign_err), 32'(exp_err));
      chk("cyc_hazard", 32'(bus.ld_hazard), 32'(bus.ld_check && hz));
      if (exp_q.size() > 0) begin
        chk("cyc_addr", bus.mem_addr, {exp_q[0][65:36], 2'b00});
        chk("cyc_wdata", bus.mem_wdata, exp_q[0][35:4]);
        chk("cyc_wmask", 32'(bus.mem_wmask), 32'(exp_q[0][3:0]));
      end
    end
  end

  // Driver tasks
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size);
    bus.st_valid = 1'b1;
    bus.st_addr  = addr;
    bus.st_data  = data;
    bus.st_size  = size;
    cycle();
    bus.st_valid = 1'b0;
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    checking       = 1'b0;
    exp_err        = 1'b0;
    rst_n          = 1'b0;
    bus.st_valid   = 1'b0;
    bus.st_addr    = 32'd0;
    bus.st_data    = 32'd0;
    bus.st_size    = 2'd0;
    bus.mem_wready = 1'b0;
    bus.ld_check   = 1'b0;
    bus.ld_addr    = 32'd0;
    cycle();
    cycle();
    checking = 1'b1;
    rst_n    = 1'b1;
    chk("rst_wvalid", 32'(bus.mem_wvalid), 32'd0);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_st_ready", 32'(bus.st_ready), 32'd1);
    chk("rst_misalign", 32'(bus.misalign_err), 32'd0);
    chk("rst_hazard", 32'(bus.ld_hazard), 32'd0);

    // sb to byte 3, drained immediately
    bus.mem_wready = 1'b1;
    do_store(32'h0000_1003, 32'h0000_00AB, 2'b00);
    chk("sb_wvalid", 32'(bus.mem_wvalid), 32'd1);
    chk("sb_addr", bus.mem_addr, 32'h0000_1000);
    chk("sb_mask", 32'(bus.mem_wmask), 32'h8);
    chk("sb_wdata", bus.mem_wdata, 32'hAB00_0000);
    cycle();
    chk("sb_empty_after", 32'(bus.empty), 32'd1);

    // sh upper half, then sw behind it
    bus.mem_wready = 1'b0;
    do_store(32'h0000_2002, 32'h1234_BEEF, 2'b01);
    chk("sh_addr", bus.mem_addr, 32'h0000_2000);
    chk("sh_mask", 32'(bus.mem_wmask), 32'hC);
    chk("sh_wdata", bus.mem_wdata, 32'hBEEF_0000);
    do_store(32'h0000_2004, 32'hDEAD_BEEF, 2'b10);
    chk("sh_held", bus.mem_wdata, 32'hBEEF_0000);
    bus.mem_wready = 1'b1;
    cycle();
    chk("sw_addr", bus.mem_addr, 32'h0000_2004);
    chk("sw_mask", 32'(bus.mem_wmask), 32'hF);
    chk("sw_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    cycle();
    chk("sw_empty_after", 32'(bus.empty), 32'd1);

    // Fill to DEPTH with dmem stalled, then drain in order
    bus.mem_wready = 1'b0;
    for (int i = 0; i < 4; i++) do_store(32'h10 + 32'(4 * i), 32'h1000_0000 + 32'(i), 2'b10);
    chk("full_st_ready", 32'(bus.st_ready), 32'd0);
    do_store(32'h0000_0020, 32'hFFFF_FFFF, 2'b10);
    chk("full_head_addr", bus.mem_addr, 32'h0000_0010);
    chk("full_still_full", 32'(bus.st_ready), 32'd0);
    bus.mem_wready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      cycle();
      chk("drain_addr", bus.mem_addr, 32'h10 + 32'(4 * i));
      chk("drain_wdata", bus.mem_wdata, 32'h1000_0000 + 32'(i));
      chk("drain_st_ready", 32'(bus.st_ready), 32'd1);
    end
    cycle();
    chk("drain_empty", 32'(bus.empty), 32'd1);

    // Back-to-back stores with simultaneous dequeue
    for (int i = 0; i < 3; i++) do_store(32'h0000_0100 + 32'(i), 32'h0000_00C0 + 32'(i), 2'b00);
    cycle();

    // Load hazard against a pending word
    bus.mem_wready = 1'b0;
    do_store(32'h0000_3000, 32'h5555_AAAA, 2'b10);
    bus.ld_check = 1'b1;
    bus.ld_addr  = 32'h0000_3002;
    #1;
    chk("hz_hit", 32'(bus.ld_hazard), 32'd1);
    bus.ld_addr = 32'h0000_3004;
    #1;
    chk("hz_other_word", 32'(bus.ld_hazard), 32'd0);
    bus.mem_wready = 1'b1;
    cycle();
    bus.mem_wready = 1'b0;
    bus.ld_addr    = 32'h0000_3002;
    #1;
    chk("hz_after_drain", 32'(bus.ld_hazard), 32'd0);
    bus.ld_check = 1'b0;

    // Misaligned and illegal stores: one-cycle error pulse, nothing queued
    do_store(32'h0000_4001, 32'h1111_1111, 2'b10);
    chk("mis_sw_err", 32'(bus.misalign_err), 32'd1);
    chk("mis_sw_wvalid", 32'(bus.mem_wvalid), 32'd0);
    cycle();
    chk("mis_sw_pulse", 32'(bus.misalign_err), 32'd0);
    do_store(32'h0000_4003, 32'h2222_2222, 2'b01);
    chk("mis_sh_err", 32'(bus.misalign_err), 32'd1);
    cycle();
    chk("mis_sh_pulse", 32'(bus.misalign_err), 32'd0);
    do_store(32'h0000_4000, 32'h3333_3333, 2'b11);
    chk("mis_ill_err", 32'(bus.misalign_err), 32'd1);
    chk("mis_ill_empty", 32'(bus.empty), 32'd1);
    cycle();
    chk("mis_ill_pulse", 32'(bus.misalign_err), 32'd0);

    // Reset with three pending entries discards them
    for (int i = 0; i < 3; i++) do_store(32'h5000 + 32'(4 * i), 32'h7000_0000 + 32'(i), 2'b10);
    chk("mrst_pending", 32'(bus.mem_wvalid), 32'd1);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    chk("mrst_wvalid", 32'(bus.mem_wvalid), 32'd0);
    chk("mrst_empty", 32'(bus.empty), 32'd1);
    chk("mrst_st_ready", 32'(bus.st_ready), 32'd1);
    bus.mem_wready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("mrst_no_write", 32'(bus.mem_wvalid), 32'd0);
    end

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Memory-write side of the core's data path; the load path extracts and writes back loaded data, while this block aligns and queues store data.
- Accepts stores from the execute stage, generates word-aligned address, shifted data and byte mask, and queues them in a FIFO.
- Drains the FIFO to data memory through a valid/ready handshake.
- Flags loads that hit a pending store so the pipeline can stall.

Parameters:
DEPTH, 4, number of FIFO entries; power of two, >= 2
CNT_W, $clog2(DEPTH+1), occupancy counter width

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  synchronous active-low reset
st_valid  input  1  store request valid
st_ready  output  1  buffer can accept a store this cycle
st_addr  input  32  byte address of store
st_data  input  32  rs2 value, unaligned (byte/half in low bits)
st_size  input  2  00 sb, 01 sh, 10 sw, 11 illegal
mem_wvalid  output  1  head entry valid toward dmem
mem_wready  input  1  dmem accepts write
mem_addr  output  32  word-aligned address, bits [1:0] = 0
mem_wdata  output  32  lane-shifted write data
mem_wmask  output  4  byte enables
ld_check  input  1  a load is in execute this cycle
ld_addr  input  32  load byte address
ld_hazard  output  1  load word matches a pending store
empty  output  1  no entries pending
misalign_err  output  1  one-cycle pulse: rejected store

Behaviour:
- Reset (rst_n=0 at a clk edge): count=0, read/write pointers=0, all entry valid bits=0.
- Reset outputs: mem_wvalid=0, empty=1, misalign_err=0, ld_hazard=0, st_ready=1.
- Reset mid-operation discards all pending stores; no partial drain.
- Enqueue condition: st_valid && st_ready && aligned.
- Alignment: sb is always aligned; sh requires addr[0]=0; sw requires addr[1:0]=00; size 11 is never aligned.
- A misaligned or illegal request is dropped: no enqueue, misalign_err=1 on the following cycle for exactly one cycle.
- st_ready = (count != DEPTH). It is not a function of mem_wready, so there is no combinational path from dmem to the execute stage.
- Alignment, with off = addr[1:0]:
  - sb: mask = 4'b0001 << off; wdata = st_data[7:0] << (8*off).
  - sh: mask = 4'b0011 << off; wdata = st_data[15:0] << (8*off).
  - sw: mask = 4'b1111; wdata = st_data.
  - Unmasked byte lanes of wdata are 0.
  - Entry stores {addr[31:2], wdata, mask}.
- Latency: an accepted store is visible at mem_* on the next cycle at the earliest. There is no same-cycle bypass.
- Drain: mem_wvalid = !empty; mem_addr, mem_wdata and mem_wmask come from the head entry.
- Head outputs are held stable while mem_wvalid && !mem_wready.
- Dequeue occurs on mem_wvalid && mem_wready; entries drain in strict FIFO order.
- Count update:
  - enqueue only: +1.
  - dequeue only: -1.
  - both in the same cycle: unchanged, and both pointers advance.
  - When full, no enqueue occurs; a dequeue that cycle frees a slot starting the next cycle.
- Pointers wrap modulo DEPTH.
- ld_hazard (combinational) = ld_check && any valid entry has word address == ld_addr[31:2].
  - The compare ignores mask: conservative.
  - The head entry is included even during the cycle it is being dequeued.
  - A store being enqueued in the same cycle is NOT compared. The pipeline guarantees a one-cycle separation.
- empty = (count == 0).

Test Plan:
- sb st_addr=0x0000_1003, st_data=0x0000_00AB, mem_wready=1 -> next cycle mem_wvalid=1, mem_addr=0x0000_1000, mem_wmask=4'b1000, mem_wdata=0xAB00_0000; empty=1 after the dequeue edge.
- sh st_addr=0x0000_2002, st_data=0x1234_BEEF -> mem_wmask=4'b1100, mem_wdata=0xBEEF_0000; sw at 0x2004 data 0xDEAD_BEEF -> mask 4'b1111, data unchanged.
- mem_wready=0, four back-to-back sw to 0x10, 0x14, 0x18, 0x1C -> st_ready=0 after the 4th accept and a 5th st_valid is ignored. Then raise mem_wready -> writes drain in order 0x10, 0x14, 0x18, 0x1C, one per cycle, and st_ready returns to 1 the cycle after the first dequeue.
- Pending sw 0x3000 with mem_wready=0; ld_check=1, ld_addr=0x3002 -> ld_hazard=1; ld_addr=0x3004 -> 0; after the drain, ld_addr=0x3002 -> 0.
- sw at 0x4001, sh at 0x4003, st_size=11 -> each produces a misalign_err pulse of 1 cycle, count stays 0, mem_wvalid stays 0.
- Three entries pending, mem_wready=0, assert rst_n=0 for one edge -> mem_wvalid=0, empty=1, st_ready=1; raising mem_wready afterwards produces no writes.
